// File: rtl/lifo_stack_pkg.sv
// ---------------------------------------------------------------------------
// lifo_stack_pkg
//   Shared definitions for the LIFO stack slice:
//     - default word width / pointer width
//     - the 2-bit operation encoding {push,pop}
//     - a helper that returns the stack depth for a given pointer width
// ---------------------------------------------------------------------------
package lifo_stack_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Operation code is simply the concatenation {push, pop}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } stack_op_e;

  function automatic int stack_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

endpackage

// File: rtl/lifo_mem.sv
// ---------------------------------------------------------------------------
// lifo_mem
//   DEPTH x DATA_WIDTH register array for the LIFO stack.
//   Synchronous write, asynchronous (combinational) read so the stack can
//   register the popped word in the same cycle the pop is requested.
// Ports
//   clk      in   rising-edge clock
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write word
//   rd_addr  in   read index
//   rd_data  out  word at rd_addr (combinational)
// ---------------------------------------------------------------------------
module lifo_mem
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = stack_depth(ADDR_WIDTH);

  // Contents are deliberately not reset: the stack pointer alone defines
  // which words are meaningful.
  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/lifo_stack.sv
// ---------------------------------------------------------------------------
// lifo_stack
//   Synchronous LIFO stack with push/pop control, saturating stack pointer
//   and registered status pulses.
// Ports
//   control_clock   in   rising-edge clock
//   reset           in   synchronous active-high reset, dominates push/pop
//   push            in   push data_in on top of stack
//   pop             in   pop top of stack into data_out
//   data_in         in   word to push
//   data_out        out  last popped word (registered)
//   data_valid      out  1-cycle pulse, data_out updated
//   full            out  stack_pointer == DEPTH
//   empty           out  stack_pointer == 0
//   overflow_flag   out  1-cycle pulse, push rejected on full stack
//   underflow_flag  out  1-cycle pulse, pop rejected on empty stack
//   stack_pointer   out  number of stored words, 0..DEPTH
// ---------------------------------------------------------------------------
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  control_clock,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow_flag,
  output logic                  underflow_flag,
  output logic [ADDR_WIDTH:0]   stack_pointer
);

  localparam int DEPTH = stack_depth(ADDR_WIDTH);
  // Pointer carries one extra bit so that DEPTH itself is representable.
  localparam logic [ADDR_WIDTH:0] SP_FULL = (ADDR_WIDTH+1)'(DEPTH);

  logic [ADDR_WIDTH:0]   sp_reg;
  logic [DATA_WIDTH-1:0] data_out_reg;
  logic                  data_valid_reg;
  logic                  overflow_reg;
  logic                  underflow_reg;

  stack_op_e             op;
  logic                  is_full;
  logic                  is_empty;
  logic [ADDR_WIDTH-1:0] top_idx;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  assign op       = stack_op_e'({push, pop});
  assign is_full  = (sp_reg == SP_FULL);
  assign is_empty = (sp_reg == '0);

  // Index of the current top word: (sp-1) truncated to ADDR_WIDTH bits.
  // Only used when the stack is non-empty, so the wrap at sp=0 is harmless.
  assign top_idx = sp_reg[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);

  // Write port: a plain push lands at sp, a push&pop overwrites the top word.
  // Reset suppresses every write in its cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = sp_reg[ADDR_WIDTH-1:0];
    if (!reset) begin
      case (op)
        OP_PUSH: wr_en = !is_full;
        OP_BOTH: begin
          if (!is_empty) begin
            wr_en   = 1'b1;
            wr_addr = top_idx;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  lifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (control_clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_addr (top_idx),
    .rd_data (rd_data)
  );

  // Pointer, data_out and the three status pulses. Pulses default low every
  // cycle, and each op branch raises at most one of them, which keeps them
  // mutually exclusive.
  always_ff @(posedge control_clock) begin
    if (reset) begin
      sp_reg         <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
      case (op)
        OP_PUSH: begin
          if (is_full) begin
            overflow_reg <= 1'b1;
          end else begin
            sp_reg <= sp_reg + 1'b1;
          end
        end
        OP_POP: begin
          if (is_empty) begin
            underflow_reg <= 1'b1;
          end else begin
            data_out_reg   <= rd_data;
            data_valid_reg <= 1'b1;
            sp_reg         <= sp_reg - 1'b1;
          end
        end
        OP_BOTH: begin
          // Replace-top returns the old top word; on an empty stack the
          // incoming word is bypassed straight to data_out.
          data_out_reg   <= is_empty ? data_in : rd_data;
          data_valid_reg <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign stack_pointer  = sp_reg;
  assign data_out       = data_out_reg;
  assign data_valid     = data_valid_reg;
  assign overflow_flag  = overflow_reg;
  assign underflow_flag = underflow_reg;
  assign full           = is_full;
  assign empty          = is_empty;

endmodule

// File: tb/tb_lifo_stack.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack
//   Self-checking bench for lifo_stack. A behavioural stack model predicts
//   pointer/flags each cycle; words expected on data_out are queued when the
//   pop is driven and compared when the DUT raises data_valid.
// ---------------------------------------------------------------------------
module tb_lifo_stack;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          control_clock = 1'b0;
  logic          reset   = 1'b0;
  logic          push    = 1'b0;
  logic          pop     = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          overflow_flag;
  logic          underflow_flag;
  logic [AW:0]   stack_pointer;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            model_sp   = 0;
  logic [DW-1:0] model_dout = '0;

  lifo_stack #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .control_clock  (control_clock),
    .reset          (reset),
    .push           (push),
    .pop            (pop),
    .data_in        (data_in),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .full           (full),
    .empty          (empty),
    .overflow_flag  (overflow_flag),
    .underflow_flag (underflow_flag),
    .stack_pointer  (stack_pointer)
  );

  always #5 control_clock = ~control_clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then check after the edge.
  task automatic step(input logic r, input logic p, input logic q,
                      input logic [DW-1:0] d, input string tag);
    logic e_valid;
    logic e_ovf;
    logic e_unf;
    e_valid = 1'b0;
    e_ovf   = 1'b0;
    e_unf   = 1'b0;
    @(negedge control_clock);
    reset   = r;
    push    = p;
    pop     = q;
    data_in = d;
    if (r) begin
      model_sp   = 0;
      model_dout = '0;
    end else if (p && !q) begin
      if (model_sp == DEPTH) begin
        e_ovf = 1'b1;
      end else begin
        model_mem[model_sp] = d;
        model_sp++;
      end
    end else if (!p && q) begin
      if (model_sp == 0) begin
        e_unf = 1'b1;
      end else begin
        model_sp--;
        model_dout = model_mem[model_sp];
        exp_q.push_back(model_dout);
        e_valid = 1'b1;
      end
    end else if (p && q) begin
      if (model_sp == 0) begin
        model_dout = d;
      end else begin
        model_dout = model_mem[model_sp-1];
        model_mem[model_sp-1] = d;
      end
      exp_q.push_back(model_dout);
      e_valid = 1'b1;
    end
    @(posedge control_clock);
    #1;
    $display("%-12s rst=%b push=%b pop=%b din=%02h -> sp=%0d dout=%02h valid=%b full=%b empty=%b ovf=%b unf=%b",
             tag, r, p, q, d, stack_pointer, data_out, data_valid, full, empty,
             overflow_flag, underflow_flag);
    check_val({tag, ".sp"},    32'(stack_pointer),  32'(model_sp));
    check_val({tag, ".empty"}, 32'(empty),          32'(model_sp == 0));
    check_val({tag, ".full"},  32'(full),           32'(model_sp == DEPTH));
    check_val({tag, ".valid"}, 32'(data_valid),     32'(e_valid));
    check_val({tag, ".ovf"},   32'(overflow_flag),  32'(e_ovf));
    check_val({tag, ".unf"},   32'(underflow_flag), 32'(e_unf));
    check_val({tag, ".dout"},  32'(data_out),       32'(model_dout));
    if (data_valid === 1'b1 && exp_q.size() > 0) begin
      check_val({tag, ".sb"}, 32'(data_out), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // 1. reset held two cycles with push asserted
    step(1'b1, 1'b1, 1'b0, 8'hEE, "rst_push0");
    step(1'b1, 1'b1, 1'b0, 8'hEE, "rst_push1");

    // 2. push three, pop three
    step(1'b0, 1'b1, 1'b0, 8'h11, "push11");
    step(1'b0, 1'b1, 1'b0, 8'h22, "push22");
    step(1'b0, 1'b1, 1'b0, 8'h33, "push33");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "pop3");

    // 3. fill to DEPTH, overflow, pop top
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i), "fill");
    step(1'b0, 1'b1, 1'b0, 8'hA8, "push_ovf");
    step(1'b0, 1'b0, 1'b0, 8'h00, "idle");
    step(1'b0, 1'b1, 1'b1, 8'hBB, "both_full");
    step(1'b0, 1'b0, 1'b1, 8'h00, "pop_topBB");
    for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b0, 1'b1, 8'h00, "drain");

    // 4. pop on empty: underflow, data_out held
    step(1'b0, 1'b0, 1'b1, 8'h00, "pop_unf");
    step(1'b0, 1'b0, 1'b0, 8'h00, "idle");

    // 5. replace-top and empty bypass
    step(1'b0, 1'b1, 1'b0, 8'h11, "push11");
    step(1'b0, 1'b1, 1'b0, 8'h22, "push22");
    step(1'b0, 1'b1, 1'b1, 8'h55, "both55");
    step(1'b0, 1'b0, 1'b1, 8'h00, "pop55");
    step(1'b0, 1'b0, 1'b1, 8'h00, "pop11");
    step(1'b0, 1'b1, 1'b1, 8'h77, "bypass77");

    // 6. reset mid-operation beats push; following pop underflows
    step(1'b0, 1'b1, 1'b0, 8'h11, "push11");
    step(1'b0, 1'b1, 1'b0, 8'h22, "push22");
    step(1'b0, 1'b1, 1'b0, 8'h33, "push33");
    step(1'b1, 1'b1, 1'b0, 8'h44, "rst_push44");
    step(1'b0, 1'b0, 1'b1, 8'h00, "pop_unf2");

    check_val("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
